fifo_sync_param: RTL

- Parametrised single-clock synchronous FIFO; next generation of the fixed 512x8 FIFO used between the MCU SPI/UART bridges and the FPGA data paths.
- Adds configurable width/depth, true full-depth occupancy, fill level, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Adds an optional first-word-fall-through (FWFT) read mode.
- Storage is an inferred synchronous-read RAM of 2^ADDR_WIDTH words.

---
 rtl/fifo_sync_param.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Parametrised single-clock synchronous FIFO built on an inferred
//   synchronous-read RAM of 2**ADDR_WIDTH words. All DEPTH words are usable.
//   It provides a fill level, almost-full and almost-empty thresholds, sticky
//   overflow/underflow flags and an optional first-word-fall-through read mode.
//
// Parameters
//   DATA_WIDTH    word width in bits (1..32)
//   ADDR_WIDTH    log2 of depth
//   FWFT          0 = registered read, 1 = first-word-fall-through
//   AFULL_THRESH  almost_full  when level >= value
//   AEMPTY_THRESH almost_empty when level <= value
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   enable       low = synchronous flush (data_out holds)
//   data_in      write data
//   write        write request
//   read         read request (standard) / pop (FWFT)
//   clear_err    synchronous clear of overflow/underflow
//   data_out     read data
//   rd_valid     standard: data_out updated this cycle; FWFT: ~empty
//   full         no write will be accepted
//   empty        no read will be accepted
//   almost_full  level >= AFULL_THRESH
//   almost_empty level <= AEMPTY_THRESH
//   level        words held (FWFT: includes the prefetch/output stages)
//   overflow     sticky: write requested while full
//   underflow    sticky: read requested while empty
module fifo_sync_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = LW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = LW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [ADDR_WIDTH:0]   w_level_nxt;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_rd;

  // full/empty are registered, so acceptance never sees the same-cycle
  // opposite request.
  assign w_wr = enable & write & ~r_full;
  assign w_rd = enable & read  & ~w_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_rd) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_rd && !w_wr) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      r_wptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == LP_DEPTH);
      r_afull  <= (w_level_nxt >= LP_AFULL);
      r_aempty <= (w_level_nxt <= LP_AEMPTY);
      // A new error in the same cycle as clear_err wins.
      r_ovf    <= (r_ovf & ~clear_err) | (write & r_full);
      r_unf    <= (r_unf & ~clear_err) | (read & w_empty);
    end
  end

  assign full         = r_full;
  assign empty        = w_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  generate
    if (FWFT == 0) begin : g_std
      logic [ADDR_WIDTH-1:0] r_rptr;
      logic [DATA_WIDTH-1:0] r_ram_q;
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_rd_pend;
      logic                  r_rd_valid;
      logic                  r_empty;

      assign w_empty = r_empty;

      always_ff @(posedge clk) begin
        if (w_rd) begin
          r_ram_q <= r_mem[r_rptr];
        end
      end

      // RAM read on the accepting edge, output register one edge later.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_rptr     <= '0;
          r_rd_pend  <= 1'b0;
          r_rd_valid <= 1'b0;
          r_empty    <= 1'b1;
          r_dout     <= '0;
        end else if (!enable) begin
          r_rptr     <= '0;
          r_rd_pend  <= 1'b0;
          r_rd_valid <= 1'b0;
          r_empty    <= 1'b1;
        end else begin
          if (w_rd) begin
            r_rptr <= r_rptr + 1'b1;
          end
          r_rd_pend  <= w_rd;
          r_rd_valid <= r_rd_pend;
          if (r_rd_pend) begin
            r_dout <= r_ram_q;
          end
          r_empty <= (w_level_nxt == '0);
        end
      end

      assign data_out = r_dout;
      assign rd_valid = r_rd_valid;
    end else begin : g_fwft
      logic [ADDR_WIDTH-1:0] r_rptr;
      logic [ADDR_WIDTH:0]   r_ram_cnt;
      logic [DATA_WIDTH-1:0] r_q;
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_qvalid;
      logic                  r_ovalid;
      logic                  w_s2_load;
      logic                  w_ram_rd;

      // Two-stage prefetch: r_q is the RAM read register, r_dout the visible
      // head. Keeping r_q full lets back-to-back pops run without a bubble.
      assign w_empty   = ~r_ovalid;
      assign w_s2_load = enable & r_qvalid & (~r_ovalid | w_rd);
      assign w_ram_rd  = enable & (r_ram_cnt != '0) & (~r_qvalid | w_s2_load);

      always_ff @(posedge clk) begin
        if (w_ram_rd) begin
          r_q <= r_mem[r_rptr];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_rptr    <= '0;
          r_ram_cnt <= '0;
          r_qvalid  <= 1'b0;
          r_ovalid  <= 1'b0;
          r_dout    <= '0;
        end else if (!enable) begin
          r_rptr    <= '0;
          r_ram_cnt <= '0;
          r_qvalid  <= 1'b0;
          r_ovalid  <= 1'b0;
        end else begin
          if (w_ram_rd) begin
            r_rptr <= r_rptr + 1'b1;
          end
          case ({w_wr, w_ram_rd})
            2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
            2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
            default: r_ram_cnt <= r_ram_cnt;
          endcase
          if (w_ram_rd) begin
            r_qvalid <= 1'b1;
          end else if (w_s2_load) begin
            r_qvalid <= 1'b0;
          end
          if (w_s2_load) begin
            r_ovalid <= 1'b1;
            r_dout   <= r_q;
          end else if (w_rd) begin
            r_ovalid <= 1'b0;
          end
        end
      end

      assign data_out = r_dout;
      assign rd_valid = r_ovalid;
    end
  endgenerate

endmodule
